kernel_kcore_h2v_hls_deadlock_report_unit: RTL and testbench

Central collector and controller for the per-process deadlock detect units of the h2v dataflow region. It monitors every unit's local detect output and confirms a deadlock. It then selects one origin process, walks the report token around the dependency cycle, and issues token_clear when the token returns to the origin. The result (origin id, participating-process mask, trace length, timeout flag) is presented on a valid/ready report port.

---
 rtl/kernel_kcore_h2v_hls_deadlock_report_unit.sv | 135 +++++++++++++
 tb/tb_kernel_kcore_h2v_hls_deadlock_report_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/kernel_kcore_h2v_hls_deadlock_report_unit.sv
// Deadlock report unit: confirms a deadlock from the per-process detect units,
// walks the report token around the dependency cycle and presents the result on a valid/ready port.
module kernel_kcore_h2v_hls_deadlock_report_unit #(
   parameter int unsigned PROC_NUM       = 4,
   parameter int unsigned CONFIRM_CYCLES = 8,
   parameter int unsigned TRACE_TIMEOUT  = 255,
   parameter int unsigned CNT_W          = 8,
   parameter int unsigned ID_W           = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [PROC_NUM-1:0] dl_detect_in,
   input  logic [PROC_NUM-1:0] token_in_any,
   output logic                dl_detect_out,
   output logic [PROC_NUM-1:0] origin,
   output logic [PROC_NUM-1:0] token_clear,
   output logic                rpt_valid,
   input  logic                rpt_ready,
   output logic [ID_W-1:0]     rpt_origin_id,
   output logic [PROC_NUM-1:0] rpt_proc_mask,
   output logic [CNT_W-1:0]    rpt_cycles,
   output logic                rpt_timeout
);

   localparam int unsigned CONF_W = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ORIGIN = 3'd1,
      TRACE  = 3'd2,
      REPORT = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t              state_q;
   logic [CONF_W-1:0]   conf_q;
   logic [ID_W-1:0]     org_q;
   logic                dl_q;
   logic [PROC_NUM-1:0] origin_q;
   logic [PROC_NUM-1:0] mask_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic                timeout_q;
   logic                valid_q;
   logic [ID_W-1:0]     low_idx_c;
   logic                ret_c;

   // Lowest set index of a detect vector (origin selection rule).
   function automatic logic [ID_W-1:0] lowest_idx(input logic [PROC_NUM-1:0] v);
      lowest_idx = '0;
      for (int i = int'(PROC_NUM) - 1; i >= 0; i--) begin
         if (v[i]) lowest_idx = ID_W'(i);
      end
   endfunction

   assign low_idx_c = lowest_idx(dl_detect_in);
   assign cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

   // Token is back home when the origin both receives it and still reports its detect.
   assign ret_c       = (state_q == TRACE) && token_in_any[org_q] && dl_detect_in[org_q];
   assign token_clear = ret_c ? (PROC_NUM'(1) << org_q) : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         conf_q    <= '0;
         org_q     <= '0;
         dl_q      <= 1'b0;
         origin_q  <= '0;
         mask_q    <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         origin_q <= '0;
         case (state_q)
            IDLE: begin
               if (|dl_detect_in) begin
                  if (conf_q == CONF_W'(CONFIRM_CYCLES - 1)) begin
                     org_q    <= low_idx_c;
                     dl_q     <= 1'b1;
                     origin_q <= PROC_NUM'(1) << low_idx_c;
                     conf_q   <= '0;
                     state_q  <= ORIGIN;
                  end else begin
                     conf_q <= conf_q + CONF_W'(1);
                  end
               end else begin
                  conf_q <= '0;
               end
            end
            ORIGIN: begin
               mask_q  <= PROC_NUM'(1) << org_q;
               cnt_q   <= '0;
               state_q <= TRACE;
            end
            TRACE: begin
               mask_q <= mask_q | token_in_any;
               cnt_q  <= cnt_d;
               // Return takes priority over a coincident timeout.
               if (ret_c) begin
                  timeout_q <= 1'b0;
                  valid_q   <= 1'b1;
                  state_q   <= REPORT;
               end else if (cnt_d == CNT_W'(TRACE_TIMEOUT)) begin
                  timeout_q <= 1'b1;
                  valid_q   <= 1'b1;
                  state_q   <= REPORT;
               end
            end
            REPORT: begin
               if (rpt_ready) begin
                  valid_q <= 1'b0;
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= DONE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign dl_detect_out = dl_q;
   assign origin        = origin_q;
   assign rpt_valid     = valid_q;
   assign rpt_origin_id = org_q;
   assign rpt_proc_mask = mask_q;
   assign rpt_cycles    = cnt_q;
   assign rpt_timeout   = timeout_q;

endmodule

// File: tb/tb_kernel_kcore_h2v_hls_deadlock_report_unit.sv
// Directed bench for the deadlock report unit: behavioural model checked every cycle
// plus hand-computed literal expectations for each scenario.
module tb_kernel_kcore_h2v_hls_deadlock_report_unit;

   localparam int unsigned P    = 4;
   localparam int unsigned CONF = 8;
   localparam int unsigned TOUT = 5;
   localparam int unsigned CW   = 8;
   localparam int unsigned IW   = 2;

   logic          clock = 1'b0;
   logic          rst_n = 1'b0;
   logic [P-1:0]  det   = '0;
   logic [P-1:0]  tok   = '0;
   logic          rdy   = 1'b0;
   logic          dl_out;
   logic [P-1:0]  origin;
   logic [P-1:0]  token_clear;
   logic          rpt_valid;
   logic [IW-1:0] rpt_origin_id;
   logic [P-1:0]  rpt_proc_mask;
   logic [CW-1:0] rpt_cycles;
   logic          rpt_timeout;

   int checks   = 0;
   int failures = 0;
   int hs       = 0;

   kernel_kcore_h2v_hls_deadlock_report_unit #(
      .PROC_NUM(P), .CONFIRM_CYCLES(CONF), .TRACE_TIMEOUT(TOUT), .CNT_W(CW), .ID_W(IW)
   ) dut (
      .clock(clock), .reset(rst_n), .dl_detect_in(det), .token_in_any(tok),
      .dl_detect_out(dl_out), .origin(origin), .token_clear(token_clear),
      .rpt_valid(rpt_valid), .rpt_ready(rdy), .rpt_origin_id(rpt_origin_id),
      .rpt_proc_mask(rpt_proc_mask), .rpt_cycles(rpt_cycles), .rpt_timeout(rpt_timeout)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: plain bookkeeping of what has happened so far.
   // phase: 0 waiting for confirmation, 1 origin pulse, 2 walking, 3 reporting, 4 finished.
   int          m_phase = 0;
   int          m_run   = 0;
   int          m_org   = 0;
   int          m_cyc   = 0;
   logic        m_dl    = 1'b0;
   logic        m_to    = 1'b0;
   logic [P-1:0] m_mask = '0;

   always @(negedge clock) begin
      if (!rst_n) begin
         m_phase = 0; m_run = 0; m_org = 0; m_cyc = 0; m_dl = 1'b0; m_to = 1'b0; m_mask = '0;
         chk("rst_dl", 32'(dl_out), 32'd0);
         chk("rst_origin", 32'(origin), 32'd0);
         chk("rst_tclr", 32'(token_clear), 32'd0);
         chk("rst_valid", 32'(rpt_valid), 32'd0);
         chk("rst_fields", {rpt_origin_id, rpt_proc_mask, rpt_cycles, rpt_timeout}, 32'd0);
      end else begin
         automatic logic ret = (m_phase == 2) && tok[m_org] && det[m_org];
         chk("m_dl", 32'(dl_out), 32'(m_dl));
         chk("m_origin", 32'(origin), (m_phase == 1) ? (32'd1 << m_org) : 32'd0);
         chk("m_tclr", 32'(token_clear), ret ? (32'd1 << m_org) : 32'd0);
         chk("m_valid", 32'(rpt_valid), 32'(m_phase == 3));
         if (m_phase >= 3) begin
            chk("m_org_id", 32'(rpt_origin_id), 32'(m_org));
            chk("m_mask", 32'(rpt_proc_mask), 32'(m_mask));
            chk("m_cycles", 32'(rpt_cycles), 32'(m_cyc));
            chk("m_timeout", 32'(rpt_timeout), 32'(m_to));
         end
         // Advance the model with the inputs the DUT samples at the coming edge.
         case (m_phase)
            0: begin
               if (det != 0) begin
                  m_run++;
                  if (m_run == CONF) begin
                     m_org = 0;
                     while (!det[m_org]) m_org++;
                     m_dl = 1'b1;
                     m_phase = 1;
                  end
               end else m_run = 0;
            end
            1: begin m_mask = P'(1) << m_org; m_cyc = 0; m_phase = 2; end
            2: begin
               m_mask = m_mask | tok;
               if (m_cyc < 255) m_cyc++;
               if (ret) begin m_to = 1'b0; m_phase = 3; end
               else if (m_cyc == TOUT) begin m_to = 1'b1; m_phase = 3; end
            end
            3: if (rdy) m_phase = 4;
            default: ;
         endcase
      end
   end

   always @(posedge clock) if (rst_n && rpt_valid && rdy) hs++;

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc(2);
      chk("lit_reset_dl", 32'(dl_out), 32'd0);
      rst_n = 1'b1;
      cyc(1);

      // Seven cycles of detect are not enough.
      det = 4'b0100; cyc(7);
      det = 4'b0000; cyc(2);
      chk("lit_short_dl", 32'(dl_out), 32'd0);
      chk("lit_short_origin", 32'(origin), 32'd0);

      // Eight cycles confirm; lowest set index is 1.
      det = 4'b0110; cyc(8);
      chk("lit_origin", 32'(origin), 32'h2);
      chk("lit_dl_rise", 32'(dl_out), 32'd1);
      det = 4'b0000; cyc(1);
      chk("lit_origin_pulse", 32'(origin), 32'h0);
      tok = 4'b0100; cyc(1);
      tok = 4'b1000; cyc(1);
      tok = 4'b0010; det = 4'b0010; #1;
      chk("lit_tclr", 32'(token_clear), 32'h2);
      cyc(1);
      tok = 4'b0000; det = 4'b0000; #1;
      chk("lit_valid", 32'(rpt_valid), 32'd1);
      chk("lit_org_id", 32'(rpt_origin_id), 32'd1);
      chk("lit_mask", 32'(rpt_proc_mask), 32'he);
      chk("lit_cycles", 32'(rpt_cycles), 32'd3);
      chk("lit_timeout", 32'(rpt_timeout), 32'd0);
      cyc(10);
      chk("lit_hold_valid", 32'(rpt_valid), 32'd1);
      rdy = 1'b1; cyc(1);
      rdy = 1'b0;
      chk("lit_done_valid", 32'(rpt_valid), 32'd0);
      chk("lit_done_dl", 32'(dl_out), 32'd1);
      chk("lit_done_cycles", 32'(rpt_cycles), 32'd3);
      // Inputs ignored once finished.
      det = 4'b1111; tok = 4'b1111; rdy = 1'b1; cyc(4);
      det = 4'b0000; tok = 4'b0000; rdy = 1'b0; cyc(1);
      chk("lit_handshakes", 32'(hs), 32'd1);
      chk("lit_done_mask", 32'(rpt_proc_mask), 32'he);

      // Reset during the walk aborts everything immediately.
      rst_n = 1'b0; cyc(1); rst_n = 1'b1;
      det = 4'b1000; cyc(8);
      chk("lit_origin3", 32'(origin), 32'h8);
      det = 4'b0000; cyc(1);
      tok = 4'b1000; det = 4'b1000; #1;
      chk("lit_tclr3", 32'(token_clear), 32'h8);
      #1 rst_n = 1'b0;
      #1;
      chk("lit_async_dl", 32'(dl_out), 32'd0);
      chk("lit_async_tclr", 32'(token_clear), 32'd0);
      chk("lit_async_origin", 32'(origin), 32'd0);
      cyc(1);
      rst_n = 1'b1; tok = 4'b0000; det = 4'b0000; cyc(3);
      chk("lit_no_restart", 32'(dl_out), 32'd0);

      // Token never returns: timeout after five walk cycles.
      det = 4'b0001; cyc(8);
      chk("lit_origin0", 32'(origin), 32'h1);
      det = 4'b0000; cyc(1);
      tok = 4'b0100; cyc(1);
      tok = 4'b0010; det = 4'b0001; #1;
      chk("lit_no_tclr", 32'(token_clear), 32'h0);
      cyc(1);
      tok = 4'b0000; det = 4'b0000; cyc(3);
      chk("lit_to_valid", 32'(rpt_valid), 32'd1);
      chk("lit_to_flag", 32'(rpt_timeout), 32'd1);
      chk("lit_to_cycles", 32'(rpt_cycles), 32'd5);
      chk("lit_to_mask", 32'(rpt_proc_mask), 32'h7);
      rdy = 1'b1; cyc(1); rdy = 1'b0; cyc(1);

      // Return on the timeout cycle: return wins.
      rst_n = 1'b0; cyc(1); rst_n = 1'b1;
      det = 4'b0100; cyc(8);
      det = 4'b0000; cyc(1);
      cyc(4);
      tok = 4'b0100; det = 4'b0100; #1;
      chk("lit_tie_tclr", 32'(token_clear), 32'h4);
      cyc(1);
      tok = 4'b0000; det = 4'b0000; #1;
      chk("lit_tie_timeout", 32'(rpt_timeout), 32'd0);
      chk("lit_tie_cycles", 32'(rpt_cycles), 32'd5);
      chk("lit_tie_id", 32'(rpt_origin_id), 32'd2);
      chk("lit_tie_mask", 32'(rpt_proc_mask), 32'h4);
      rdy = 1'b1; cyc(1); rdy = 1'b0; cyc(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
